fx2_bus_sched: RTL and testbench
================================

// Module: fx2_bus_sched
// PURPOSE
//  Sequences the FX2 slave-FIFO bus between the two endpoint FIFOs on the FPGA side.
//  Drains host commands from OUT endpoint EP2 (fifoadr 2'b00) into a byte strobe.
//  Streams timetag record bytes into IN endpoint EP6 (fifoadr 2'b10).
//  Issues pktend for short packets and owns fd direction and bus turnaround.
// PARAMETERS
//  OUT_ADR       2'b00  fifoadr of host->device endpoint (EP2)
//  IN_ADR        2'b10  fifoadr of device->host endpoint (EP6)
//  PKT_SIZE      512    EP6 packet size in bytes; FX2 auto-commits at this count
//  WR_BURST_MAX  64     max consecutive EP6 writes before re-arbitrating
//  PKTEND_TMO    4096   idle cycles before auto pktend (AUTO_PKTEND_EN only)
// PORTS
//  ifclk      in   1  FX2 interface clock; all logic on posedge
//  reset      in   1  synchronous, active-high
//  fd_in      in   8  fd bus as driven by FX2
//  fd_out     out  8  fd value driven by FPGA
//  fd_oe      out  1  1 = FPGA drives fd
//  sloe       out  1  1 = FX2 drives fd (active-high)
//  slrd       out  1  read strobe (active-high)
//  slwr       out  1  write strobe (active-high)
//  pktend     out  1  commit short packet (active-high, 1 cycle)
//  fifoadr    out  2  endpoint select
//  flags      in   4  [0] EP2 empty, [1] EP6 full, [3:2] unused
//  cmd_data   out  8  byte read from EP2
//  cmd_valid  out  1  1-cycle strobe; no backpressure once issued
//  cmd_ready  in   1  consumer can take a byte; gates slrd
//  in_data    in   8  byte to send to EP6
//  in_valid   in   1  in_data valid
//  in_ready   out  1  byte accepted this cycle (== slwr)
//  flush      in   1  1-cycle request to commit partial EP6 packet
//  flush_done out  1  1-cycle ack of flush
// BEHAVIOUR
//  Reset values: all outputs 0, fifoadr=IN_ADR, state IDLE, pkt_cnt=0, flush_pend=0.
//  States: IDLE, RD_SETUP, RD, TURN, WR_SETUP, WR, PKTEND.
//  IDLE: if !flags[0]&&cmd_ready -> RD_SETUP; else if flush_pend -> WR_SETUP; else if in_valid -> WR_SETUP.
//   Read has priority.
//  RD_SETUP (1 cyc): fifoadr=OUT_ADR, sloe=1, fd_oe=0 -> RD.
//  RD: slrd = !flags[0]&&cmd_ready. Byte sampled at edge of slrd cycle N appears on cmd_data with cmd_valid in cycle N+1.
//   Exit to TURN when flags[0] or !cmd_ready.
//  TURN (1 cyc): sloe=0, fd_oe=0; guarantees no bus contention -> IDLE.
//  WR_SETUP (1 cyc): fifoadr=IN_ADR, fd_oe=1 -> WR (or PKTEND if flush_pend and no in_valid).
//  WR: slwr=in_ready=in_valid&&!flags[1]; fd_out=in_data combinationally.
//   Exit to IDLE (fd_oe drops same cycle) when: !in_valid; burst count hits WR_BURST_MAX while EP2 non-empty; or flags[1].
//   On exit with flush_pend, go to PKTEND instead.
//  pkt_cnt (10b): +1 per slwr; wraps to 0 when it reaches PKT_SIZE-1 and is written (FX2 auto-commit).
//  flush sets flush_pend (sticky; a repeat flush while pending is absorbed).
//  PKTEND (1 cyc): pktend=1 iff pkt_cnt!=0 && !flags[1]; if full, hold in PKTEND until !flags[1].
//   On leaving: pkt_cnt=0, flush_pend=0, flush_done=1 -> IDLE.
//   Flush with pkt_cnt==0: no pktend (no ZLP), flush_done still pulses.
//  Simultaneous slwr and flush in the same cycle: the byte is counted before pktend.
//  fd_oe and sloe never both 1; always >=1 cycle with both 0 between direction changes.
//  reset mid-burst: strobes drop next edge; any partial packet is lost (FX2 side reset by host).
// CONFIGURATION
//  AUTO_PKTEND_EN defined: idle counter runs while pkt_cnt!=0 && !in_valid, cleared by any slwr.
//   At PKTEND_TMO it sets flush_pend internally (no flush_done pulse for internal flushes).
//  AUTO_PKTEND_EN undefined: counter absent; pktend only via flush.
// TESTING
//  Reset: all strobes 0, fd_oe=0, fifoadr=2'b10 after 1 edge.
//  EP2 holds 3 bytes A1 B2 C3, cmd_ready=1 -> 3 slrd pulses; cmd_valid x3 with A1,B2,C3 one cycle later; then TURN.
//  Stream 1030 bytes, EP6 never full, no reads -> 1030 slwr, pkt_cnt=6 at end, no pktend.
//  Then flush -> one pktend; flush_done 1 cycle later; a second flush -> flush_done, no pktend.
//  EP2 non-empty during 200-byte stream -> write burst stops at 64, read runs, sloe/fd_oe never overlap.
//  flags[1]=1 mid-write -> slwr=0, in_ready=0 same cycle; no byte lost when full clears.
//  AUTO_PKTEND_EN, 5 bytes then idle -> pktend exactly PKTEND_TMO cycles after last slwr.

Source files
------------

// File: rtl/fx2_bus_sched.sv
`default_nettype none
// ============================================================================
//  Module      : fx2_bus_sched
//  Description : FX2 slave-FIFO bus scheduler. Reads host commands from EP2,
//                streams record bytes into EP6, issues pktend on flush and owns
//                fd direction and bus turnaround. Optional AUTO_PKTEND_EN adds
//                an idle timeout that commits short packets without a flush.
//  Revision    : 1.0 - initial release
// ============================================================================
module fx2_bus_sched #(
    parameter logic [1:0] OUT_ADR      = 2'b00,
    parameter logic [1:0] IN_ADR       = 2'b10,
    parameter int         PKT_SIZE     = 512,
    parameter int         WR_BURST_MAX = 64,
    parameter int         PKTEND_TMO   = 4096
) (
    input  logic       ifclk,
    input  logic       reset,
    input  logic [7:0] fd_in,
    output logic [7:0] fd_out,
    output logic       fd_oe,
    output logic       sloe,
    output logic       slrd,
    output logic       slwr,
    output logic       pktend,
    output logic [1:0] fifoadr,
    input  logic [3:0] flags,
    output logic [7:0] cmd_data,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       flush,
    output logic       flush_done
);

    localparam int c_BURST_W = $clog2(WR_BURST_MAX + 1);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_RD_SETUP = 3'd1,
        S_RD       = 3'd2,
        S_TURN     = 3'd3,
        S_WR_SETUP = 3'd4,
        S_WR       = 3'd5,
        S_PKTEND   = 3'd6
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [9:0]           r_pkt_cnt;
    logic [c_BURST_W-1:0] r_burst_cnt;
    logic                 r_flush_pend;
    logic                 r_flush_ext;
    logic                 r_cmd_valid;
    logic [7:0]           r_cmd_data;
    logic                 r_flush_done;

    logic w_ep2_empty;
    logic w_ep6_full;
    logic w_rd_ok;
    logic w_wr_ok;
    logic w_burst_hit;
    logic w_pkt_leave;
    logic w_auto_flush;
    logic w_unused;

    assign w_ep2_empty = flags[0];
    assign w_ep6_full  = flags[1];
    assign w_rd_ok     = !w_ep2_empty && cmd_ready;
    assign w_wr_ok     = in_valid && !w_ep6_full;
    // The current write is the last one of the burst when EP2 is waiting.
    assign w_burst_hit = !w_ep2_empty && (r_burst_cnt >= c_BURST_W'(WR_BURST_MAX - 1));
    assign w_unused    = &{1'b0, flags[3:2]};

    assign in_ready   = slwr;
    assign cmd_valid  = r_cmd_valid;
    assign cmd_data   = r_cmd_data;
    assign flush_done = r_flush_done;

    always_comb begin
        w_state_next = r_state;
        fd_oe        = 1'b0;
        sloe         = 1'b0;
        slrd         = 1'b0;
        slwr         = 1'b0;
        pktend       = 1'b0;
        fd_out       = 8'h00;
        fifoadr      = IN_ADR;
        w_pkt_leave  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_rd_ok)
                    w_state_next = S_RD_SETUP;
                else if (r_flush_pend || in_valid)
                    w_state_next = S_WR_SETUP;
            end
            S_RD_SETUP: begin
                fifoadr      = OUT_ADR;
                sloe         = 1'b1;
                w_state_next = S_RD;
            end
            S_RD: begin
                fifoadr = OUT_ADR;
                sloe    = 1'b1;
                slrd    = w_rd_ok;
                if (!w_rd_ok)
                    w_state_next = S_TURN;
            end
            S_TURN: begin
                fifoadr      = OUT_ADR;
                w_state_next = S_IDLE;
            end
            S_WR_SETUP: begin
                fd_oe        = 1'b1;
                w_state_next = (r_flush_pend && !in_valid) ? S_PKTEND : S_WR;
            end
            S_WR: begin
                fd_oe  = 1'b1;
                slwr   = w_wr_ok;
                fd_out = in_data;
                if (!in_valid || w_ep6_full || w_burst_hit)
                    w_state_next = r_flush_pend ? S_PKTEND : S_IDLE;
            end
            S_PKTEND: begin
                // An empty packet is never committed; a full EP6 holds the commit.
                if (r_pkt_cnt == 10'd0) begin
                    w_pkt_leave = 1'b1;
                end else if (!w_ep6_full) begin
                    pktend      = 1'b1;
                    w_pkt_leave = 1'b1;
                end
                if (w_pkt_leave)
                    w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge ifclk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_pkt_cnt    <= 10'd0;
            r_burst_cnt  <= '0;
            r_flush_pend <= 1'b0;
            r_flush_ext  <= 1'b0;
            r_cmd_valid  <= 1'b0;
            r_cmd_data   <= 8'h00;
            r_flush_done <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cmd_valid <= slrd;
            if (slrd)
                r_cmd_data <= fd_in;

            // FX2 auto-commits a full packet, so the count restarts there.
            if (slwr)
                r_pkt_cnt <= (r_pkt_cnt == 10'(PKT_SIZE - 1)) ? 10'd0 : r_pkt_cnt + 10'd1;

            if (r_state == S_WR_SETUP)
                r_burst_cnt <= '0;
            else if (slwr && (r_burst_cnt != c_BURST_W'(WR_BURST_MAX)))
                r_burst_cnt <= r_burst_cnt + c_BURST_W'(1);

            r_flush_done <= w_pkt_leave && r_flush_ext;
            if (w_pkt_leave) begin
                r_pkt_cnt    <= 10'd0;
                r_flush_pend <= 1'b0;
                r_flush_ext  <= 1'b0;
            end else begin
                if (flush) begin
                    r_flush_pend <= 1'b1;
                    r_flush_ext  <= 1'b1;
                end
                if (w_auto_flush)
                    r_flush_pend <= 1'b1;
            end
        end
    end

`ifdef AUTO_PKTEND_EN
    localparam int c_IDLE_W = $clog2(PKTEND_TMO + 1);
    // Raised three cycles early so that IDLE, WR_SETUP and PKTEND put pktend on the timeout cycle.
    localparam logic [c_IDLE_W-1:0] c_AUTO_FIRE = c_IDLE_W'(PKTEND_TMO - 4);

    logic [c_IDLE_W-1:0] r_idle_cnt;
    logic                w_idle_run;

    assign w_idle_run   = (r_pkt_cnt != 10'd0) && !in_valid && !r_flush_pend;
    assign w_auto_flush = w_idle_run && (r_idle_cnt == c_AUTO_FIRE);

    always_ff @(posedge ifclk) begin
        if (reset || slwr || (r_pkt_cnt == 10'd0))
            r_idle_cnt <= '0;
        else if (w_idle_run)
            r_idle_cnt <= r_idle_cnt + c_IDLE_W'(1);
    end
`else
    localparam int c_unused_tmo = PKTEND_TMO;
    assign w_auto_flush = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fx2_bus_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fx2_bus_sched
//  Description : Directed self-checking bench for fx2_bus_sched with small
//                EP2/EP6 FIFO models and a byte-source model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fx2_bus_sched;

    logic       ifclk = 1'b0;
    logic       reset;
    logic [7:0] fd_in, fd_out, cmd_data, in_data;
    logic       fd_oe, sloe, slrd, slwr, pktend, cmd_valid, cmd_ready;
    logic       in_valid, in_ready, flush, flush_done;
    logic [1:0] fifoadr;
    logic [3:0] flags;
    logic       ep6_full;

    logic [7:0] ep2_mem [0:255];
    logic [7:0] ep2_wr, ep2_rd;
    int         src_total, src_sent;

    int n_tests, n_fail;
    int cyc, n_slwr, n_slrd, n_pktend, n_fdone, n_cmd, nb, run_len;
    int n_overlap, n_gap, n_adr, n_cv, n_data, n_underrun, n_rdy, n_fullwr;
    int t_pktend, t_fdone;
    int bursts [0:63];
    logic [7:0] cmd_log [0:255];
    logic prev_slrd = 1'b0, prev_fd_oe = 1'b0, prev_sloe = 1'b0;
`ifdef AUTO_PKTEND_EN
    int t_last_slwr;
`endif

    always #5 ifclk = ~ifclk;

    assign flags    = {2'b00, ep6_full, ep2_rd == ep2_wr};
    assign fd_in    = ep2_mem[ep2_rd];
    assign in_valid = src_sent < src_total;
    assign in_data  = 8'(src_sent) + 8'h11;

    fx2_bus_sched dut (
        .ifclk(ifclk), .reset(reset), .fd_in(fd_in), .fd_out(fd_out), .fd_oe(fd_oe),
        .sloe(sloe), .slrd(slrd), .slwr(slwr), .pktend(pktend), .fifoadr(fifoadr),
        .flags(flags), .cmd_data(cmd_data), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .flush_done(flush_done)
    );

    // FIFO models, event counters and bus-protocol monitors.
    always @(posedge ifclk) begin
        cyc        <= cyc + 1;
        prev_slrd  <= slrd;
        prev_fd_oe <= fd_oe;
        prev_sloe  <= sloe;
        if (fd_oe && sloe) n_overlap <= n_overlap + 1;
        if ((fd_oe && prev_sloe) || (sloe && prev_fd_oe)) n_gap <= n_gap + 1;
        if ((slrd && (fifoadr != 2'b00 || !sloe)) || (slwr && (fifoadr != 2'b10 || !fd_oe)))
            n_adr <= n_adr + 1;
        if (cmd_valid != prev_slrd) n_cv <= n_cv + 1;
        if (in_ready != slwr) n_rdy <= n_rdy + 1;
        if (slwr && ep6_full) n_fullwr <= n_fullwr + 1;
        if (slrd) begin
            n_slrd <= n_slrd + 1;
            if (ep2_rd == ep2_wr) n_underrun <= n_underrun + 1;
            else ep2_rd <= ep2_rd + 8'd1;
        end
        if (slwr) begin
            n_slwr   <= n_slwr + 1;
            src_sent <= src_sent + 1;
            if (fd_out != in_data) n_data <= n_data + 1;
`ifdef AUTO_PKTEND_EN
            t_last_slwr <= cyc;
`endif
        end
        if (pktend) begin
            n_pktend <= n_pktend + 1;
            t_pktend <= cyc;
        end
        if (flush_done) begin
            n_fdone <= n_fdone + 1;
            t_fdone <= cyc;
        end
        if (cmd_valid) begin
            cmd_log[n_cmd[7:0]] <= cmd_data;
            n_cmd <= n_cmd + 1;
        end
        if (!fd_oe && run_len != 0) begin
            bursts[nb[5:0]] <= run_len;
            nb      <= nb + 1;
            run_len <= 0;
        end else if (fd_oe && slwr) begin
            run_len <= run_len + 1;
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic ep2_push(input logic [7:0] b);
        ep2_mem[ep2_wr] = b;
        ep2_wr = ep2_wr + 8'd1;
    endtask

    task automatic wait_quiet(input string tag, input int budget);
        int k;
        k = 0;
        while (k < budget && !(src_sent == src_total && ep2_rd == ep2_wr && !fd_oe && !sloe)) begin
            @(negedge ifclk);
            k++;
        end
        check_eq({tag, "_timeout"}, 32'(k < budget), 32'd1);
        repeat (4) @(negedge ifclk);
    endtask

    task automatic wait_writes(input int base, input int n);
        int k;
        k = 0;
        while (k < 200 && (n_slwr - base) < n) begin
            @(negedge ifclk);
            k++;
        end
        check_eq("write_wait_timeout", 32'(k < 200), 32'd1);
    endtask

    task automatic do_flush(input string tag, input int exp_pk);
        int pk0, fd0, k;
        pk0 = n_pktend;
        fd0 = n_fdone;
        k = 0;
        flush = 1'b1;
        @(negedge ifclk);
        flush = 1'b0;
        while (k < 40 && n_fdone == fd0) begin
            @(negedge ifclk);
            k++;
        end
        repeat (3) @(negedge ifclk);
        check_eq({tag, "_done"}, 32'(n_fdone - fd0), 32'd1);
        check_eq({tag, "_pktend"}, 32'(n_pktend - pk0), 32'(exp_pk));
        if (exp_pk == 1)
            check_eq({tag, "_lat"}, 32'(t_fdone - t_pktend), 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, s0, p0, b0, c0, f0;
        logic [7:0] idx;
        for (int i = 0; i < 256; i++) ep2_mem[i] = 8'h00;
        ep2_wr = 8'd0; ep2_rd = 8'd0;
        reset = 1'b1; cmd_ready = 1'b0; flush = 1'b0; ep6_full = 1'b0; src_total = 0;
        repeat (3) @(negedge ifclk);
        check_eq("reset_strobes", {24'd0, fd_oe, sloe, slrd, slwr, pktend, cmd_valid, flush_done, in_ready}, 32'd0);
        check_eq("reset_fifoadr", 32'(fifoadr), 32'h2);
        check_eq("reset_data", {16'd0, fd_out, cmd_data}, 32'd0);
        reset = 1'b0;
        @(negedge ifclk);

        // EP2 command read: A1 B2 C3.
        s0 = n_slrd; c0 = n_cmd;
        ep2_push(8'hA1); ep2_push(8'hB2); ep2_push(8'hC3);
        cmd_ready = 1'b1;
        wait_quiet("rd3", 50);
        check_eq("rd3_slrd", 32'(n_slrd - s0), 32'd3);
        check_eq("rd3_cmds", 32'(n_cmd - c0), 32'd3);
        idx = 8'(c0);
        check_eq("rd3_byte0", 32'(cmd_log[idx]), 32'hA1);
        check_eq("rd3_byte1", 32'(cmd_log[idx + 8'd1]), 32'hB2);
        check_eq("rd3_byte2", 32'(cmd_log[idx + 8'd2]), 32'hC3);

        // 1030-byte stream, EP6 never full, no reads.
        w0 = n_slwr; p0 = n_pktend; b0 = nb;
        src_total = src_sent + 1030;
        wait_quiet("st1030", 1200);
        check_eq("st1030_writes", 32'(n_slwr - w0), 32'd1030);
        check_eq("st1030_pktend", 32'(n_pktend - p0), 32'd0);
        check_eq("st1030_burst", 32'(bursts[b0[5:0]]), 32'd1030);
        do_flush("flush6", 1);
        do_flush("flush_empty", 0);

        // Packet boundary: 511 bytes leave a short packet, 512 auto-commit.
        src_total = src_sent + 511;
        wait_quiet("st511", 600);
        do_flush("flush511", 1);
        src_total = src_sent + 512;
        wait_quiet("st512", 600);
        do_flush("flush512", 0);

        // Flush in the same cycle as the only write: byte counted first.
        src_total = src_sent + 1;
        f0 = 0;
        while (f0 < 20 && !slwr) begin
            @(negedge ifclk);
            f0++;
        end
        check_eq("flushwr_slwr", 32'(slwr), 32'd1);
        do_flush("flush_with_wr", 1);

        // EP6 full mid-write: strobes drop combinationally, nothing lost.
        w0 = n_slwr;
        src_total = src_sent + 20;
        wait_writes(w0, 5);
        check_eq("full_pre_slwr", 32'(slwr), 32'd1);
        ep6_full = 1'b1;
        #1;
        check_eq("full_strobes", {30'd0, slwr, in_ready}, 32'd0);
        repeat (6) @(negedge ifclk);
        check_eq("full_hold", 32'(n_slwr - w0), 32'd5);
        ep6_full = 1'b0;
        wait_quiet("full", 100);
        check_eq("full_total", 32'(n_slwr - w0), 32'd20);
        do_flush("flush_full", 1);

        // EP2 data arrives during a 200-byte stream: burst capped at 64.
        w0 = n_slwr; b0 = nb; c0 = n_cmd; s0 = n_slrd;
        src_total = src_sent + 200;
        wait_writes(w0, 10);
        ep2_push(8'h3C); ep2_push(8'h4D);
        wait_quiet("st200", 400);
        check_eq("st200_writes", 32'(n_slwr - w0), 32'd200);
        check_eq("st200_burst", 32'(bursts[b0[5:0]]), 32'd64);
        check_eq("st200_slrd", 32'(n_slrd - s0), 32'd2);
        idx = 8'(c0);
        check_eq("st200_cmd0", 32'(cmd_log[idx]), 32'h3C);
        check_eq("st200_cmd1", 32'(cmd_log[idx + 8'd1]), 32'h4D);
        do_flush("flush200", 1);

        // Reset mid-burst: strobes drop after the edge, partial packet lost.
        w0 = n_slwr;
        src_total = src_sent + 100;
        wait_writes(w0, 10);
        reset = 1'b1;
        @(negedge ifclk);
        check_eq("rst_mid_strobes", {30'd0, slwr, fd_oe}, 32'd0);
        src_total = src_sent;
        @(negedge ifclk);
        reset = 1'b0;
        @(negedge ifclk);
        do_flush("flush_after_rst", 0);

`ifdef AUTO_PKTEND_EN
        begin
            int k;
            p0 = n_pktend; f0 = n_fdone; k = 0;
            src_total = src_sent + 5;
            while (k < 4096 + 100 && n_pktend == p0) begin
                @(negedge ifclk);
                k++;
            end
            repeat (3) @(negedge ifclk);
            check_eq("auto_pktend", 32'(n_pktend - p0), 32'd1);
            check_eq("auto_latency", 32'(t_pktend - t_last_slwr), 32'd4096);
            check_eq("auto_no_done", 32'(n_fdone - f0), 32'd0);
        end
`endif

        check_eq("bus_overlap", 32'(n_overlap), 32'd0);
        check_eq("bus_turn_gap", 32'(n_gap), 32'd0);
        check_eq("strobe_addr", 32'(n_adr), 32'd0);
        check_eq("cmd_valid_align", 32'(n_cv), 32'd0);
        check_eq("wr_data", 32'(n_data), 32'd0);
        check_eq("ep2_underrun", 32'(n_underrun), 32'd0);
        check_eq("in_ready_eq_slwr", 32'(n_rdy), 32'd0);
        check_eq("write_when_full", 32'(n_fullwr), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
